// File: rtl/e1_tx_framer_gen2_if.sv
// e1_tx_framer_gen2_if: signal bundle of the E1 transmit framer.
//   fetch : in_req/in_rdy handshake, in_data, in_crc_e, in_sa, in_frame, in_ts, in_mf_first, in_mf_last
//   line  : out_bit, out_valid
//   timing: ctrl_time_src, ext_tick, int_tick
//   mode  : ctrl_do_framing, ctrl_do_crc4, ctrl_loopback, alarm, lb_bit, lb_valid
//   status: stat_underrun, stat_clr
// The slave modport is the framer; the master modport is the data source/controller.
interface e1_tx_framer_gen2_if #(
  parameter int UNDERRUN_W = 16
);
  logic [7:0] in_data;
  logic [1:0] in_crc_e;
  logic [4:0] in_sa;
  logic [3:0] in_frame;
  logic [4:0] in_ts;
  logic in_mf_first, in_mf_last, in_req, in_rdy;
  logic out_bit, out_valid;
  logic ctrl_time_src, ext_tick, int_tick;
  logic ctrl_do_framing, ctrl_do_crc4, ctrl_loopback, alarm;
  logic lb_bit, lb_valid;
  logic [UNDERRUN_W-1:0] stat_underrun;
  logic stat_clr;
  modport master (
    output in_data, in_crc_e, in_sa, in_rdy, ctrl_time_src, ext_tick,
           ctrl_do_framing, ctrl_do_crc4, ctrl_loopback, alarm, lb_bit, lb_valid, stat_clr,
    input  in_frame, in_ts, in_mf_first, in_mf_last, in_req, out_bit, out_valid, int_tick,
           stat_underrun
  );
  modport slave (
    input  in_data, in_crc_e, in_sa, in_rdy, ctrl_time_src, ext_tick,
           ctrl_do_framing, ctrl_do_crc4, ctrl_loopback, alarm, lb_bit, lb_valid, stat_clr,
    output in_frame, in_ts, in_mf_first, in_mf_last, in_req, out_bit, out_valid, int_tick,
           stat_underrun
  );
endinterface

// File: rtl/e1_tx_framer_gen2.sv
// e1_tx_framer_gen2: E1 transmit framer with TS0 framing, CRC-4 multiframe and byte prefetch.
//   clk, rst (async, active-high); bus : e1_tx_framer_gen2_if.slave (fetch, line, timing, mode, status).
//   Define E1_TX_SA_INSERT_EN to take Sa4..Sa8 of odd-frame TS0 from in_sa; otherwise they are 1.
module e1_tx_framer_gen2 #(
  parameter int TICK_DIV   = 15,
  parameter int UNDERRUN_W = 16
) (
  input logic clk,
  input logic rst,
  e1_tx_framer_gen2_if.slave bus
);
  logic [7:0] div_q, div_d, sh_q, sh_d, pf_q, pf_d, raw, byte_v, si_tab;
  logic tick_q, tick_d, ext_q, req_q, req_d, samp_q, ob_q, ob_d, ov_q, ov_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] frame_q, frame_d, crc_q, crc_d, smf_q, smf_d, crc_v;
  logic [4:0] ts_q, ts_d, sa;
  logic [UNDERRUN_W-1:0] und_q, und_d;
  logic boundary, cbit, si, c_slot, smf_end;

  function automatic logic [3:0] crc8(input logic [3:0] c, input logic [7:0] b);
    logic [3:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[3] ^ b[i];
      r = {r[2:1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  always_comb begin
    div_d = (div_q == 8'(TICK_DIV - 1)) ? 8'd0 : div_q + 8'd1;
    // external strobe fires on the rising edge of ext_tick only
    tick_d = ~tick_q & (bus.ctrl_time_src ? bus.ext_tick & ~ext_q : div_q == 8'(TICK_DIV - 1));
    boundary = tick_q & (bit_q == 3'd7);
    bit_d = tick_q ? bit_q + 3'd1 : bit_q;
    sh_d = boundary ? pf_q : tick_q ? {sh_q[6:0], 1'b1} : sh_q;
    req_d = boundary;
    ts_d = boundary ? ts_q + 5'd1 : ts_q;
    frame_d = (boundary && ts_q == 5'd31) ? frame_q + 4'd1 : frame_q;
    raw = bus.in_rdy ? bus.in_data : 8'hFF;
    // C1..C4 sit in frames 0,2,4,6 of each submultiframe, MSB of the captured CRC first
    cbit = ~bus.ctrl_do_crc4 | smf_q[2'd3 - frame_q[2:1]];
    si_tab = {bus.in_crc_e, 6'b110100};
    si = si_tab[frame_q[3:1]];
`ifdef E1_TX_SA_INSERT_EN
    sa = bus.in_sa;
`else
    sa = 5'h1F;
`endif
    byte_v = (!bus.ctrl_do_framing || ts_q != 5'd0) ? raw :
             frame_q[0] ? {si, 1'b1, bus.alarm, sa} : {cbit, 7'b0011011};
    c_slot = bus.ctrl_do_framing && ts_q == 5'd0 && !frame_q[0];
    crc_v = crc8(crc_q, c_slot ? {1'b0, byte_v[6:0]} : byte_v);
    smf_end = samp_q && ts_q == 5'd31 && frame_q[2:0] == 3'd7;
    pf_d = samp_q ? byte_v : pf_q;
    crc_d = !samp_q ? crc_q : smf_end ? 4'd0 : crc_v;
    smf_d = smf_end ? crc_v : smf_q;
    und_d = bus.stat_clr ? '0 : (samp_q && !bus.in_rdy && !(&und_q)) ? und_q + UNDERRUN_W'(1) : und_q;
    ob_d = bus.ctrl_loopback ? bus.lb_bit : tick_q ? sh_q[7] : ob_q;
    ov_d = bus.ctrl_loopback ? bus.lb_valid : tick_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      tick_q <= 1'b0;
      ext_q <= 1'b0;
      bit_q <= '0;
      sh_q <= 8'hFF;
      pf_q <= 8'hFF;
      req_q <= 1'b0;
      samp_q <= 1'b0;
      frame_q <= 4'd15;
      ts_q <= 5'd31;
      crc_q <= '0;
      smf_q <= 4'hF;
      und_q <= '0;
      ob_q <= 1'b1;
      ov_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tick_q <= tick_d;
      ext_q <= bus.ext_tick;
      bit_q <= bit_d;
      sh_q <= sh_d;
      pf_q <= pf_d;
      req_q <= req_d;
      samp_q <= req_q;
      frame_q <= frame_d;
      ts_q <= ts_d;
      crc_q <= crc_d;
      smf_q <= smf_d;
      und_q <= und_d;
      ob_q <= ob_d;
      ov_q <= ov_d;
    end
  end

  assign bus.in_req = req_q;
  assign bus.in_frame = frame_q;
  assign bus.in_ts = ts_q;
  assign bus.in_mf_first = frame_q == 4'd0 && ts_q == 5'd0;
  assign bus.in_mf_last = frame_q == 4'd15 && ts_q == 5'd31;
  assign bus.out_bit = ob_q;
  assign bus.out_valid = ov_q;
  assign bus.int_tick = tick_q;
  assign bus.stat_underrun = und_q;
endmodule

// File: tb/tb_e1_tx_framer_gen2.sv
module tb_e1_tx_framer_gen2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  e1_tx_framer_gen2_if #(.UNDERRUN_W(16)) bus ();
  e1_tx_framer_gen2 #(.TICK_DIV(15), .UNDERRUN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_fail = 0, cyc = 0, req_cnt = 0;
  logic [7:0] exp_q[$];
  bit smf_bits[$];
  logic [3:0] smf_c;
  int mfr, mts, model_und, force_under;
  bit mon_en, ext_en, data_rand, rdy_rand, clr_arm, clr_next;
  logic [7:0] const_data;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // remainder of (bits * x^4) / (x^4+x+1) by textbook long division
  function automatic logic [3:0] poly_rem();
    bit a[$];
    int n;
    a = smf_bits;
    n = a.size();
    repeat (4) a.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (a[i]) begin
        a[i] ^= 1'b1;
        a[i+3] ^= 1'b1;
        a[i+4] ^= 1'b1;
      end
    return {a[n], a[n+1], a[n+2], a[n+3]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    smf_bits.delete();
    smf_c = 4'hF;
    mfr = 0;
    mts = 0;
    model_und = 0;
    force_under = 0;
    clr_arm = 0;
  endtask

  task automatic respond();
    logic [7:0] d, raw, e;
    logic rdy, si;
    logic [4:0] sa_e;
    chk("in_frame", bus.in_frame, mfr);
    chk("in_ts", bus.in_ts, mts);
    chk("in_mf_first", bus.in_mf_first, (mfr == 0 && mts == 0));
    chk("in_mf_last", bus.in_mf_last, (mfr == 15 && mts == 31));
    d = data_rand ? 8'($urandom) : const_data;
    if (force_under > 0) begin
      rdy = 0;
      force_under--;
    end else rdy = rdy_rand ? ($urandom_range(0, 15) != 0) : 1'b1;
    bus.in_data = d;
    bus.in_rdy = rdy;
    bus.alarm = 1'($urandom);
    bus.in_crc_e = 2'($urandom);
    bus.in_sa = 5'($urandom);
    raw = rdy ? d : 8'hFF;
    if (!rdy) model_und++;
    if (!rdy && clr_arm) begin
      clr_next = 1;
      clr_arm = 0;
      model_und = 0;
    end
`ifdef E1_TX_SA_INSERT_EN
    sa_e = bus.in_sa;
`else
    sa_e = 5'b11111;
`endif
    case (mfr)
      1, 3, 7: si = 0;
      5, 9, 11: si = 1;
      13: si = bus.in_crc_e[0];
      default: si = bus.in_crc_e[1];
    endcase
    if (!bus.ctrl_do_framing || mts != 0) e = raw;
    else if (mfr % 2 == 0) e = {bus.ctrl_do_crc4 ? smf_c[3 - (mfr % 8) / 2] : 1'b1, 7'b0011011};
    else e = {si, 1'b1, bus.alarm, sa_e};
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--)
      smf_bits.push_back((bus.ctrl_do_framing && mts == 0 && mfr % 2 == 0 && i == 7) ? 1'b0 : e[i]);
    if (mts == 31 && mfr % 8 == 7) begin
      smf_c = poly_rem();
      smf_bits.delete();
    end
    mts = (mts + 1) % 32;
    if (mts == 0) mfr = (mfr + 1) % 16;
    req_cnt++;
  endtask

  always @(negedge clk) begin
    bus.stat_clr = clr_next;
    clr_next = 0;
    if (!rst && bus.in_req) respond();
  end

  always @(negedge clk)
    bus.ext_tick = ext_en ? (($urandom_range(0, 3) != 0) ? ~bus.ext_tick : bus.ext_tick) : 1'b0;

  logic [7:0] acc;
  int nb = 0;
  always @(negedge clk) begin
    if (rst) begin
      nb = 0;
      acc = 0;
    end else if (mon_en && bus.out_valid) begin
      acc = {acc[6:0], bus.out_bit};
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
        else chk("line_byte", acc, exp_q.pop_front());
      end
    end
  end

  task automatic run_reqs(int n);
    int tgt, lim;
    tgt = req_cnt + n;
    lim = n * 400 + 400;
    while (req_cnt < tgt && lim > 0) begin
      @(negedge clk);
      lim--;
    end
    if (req_cnt < tgt) chk("req_timeout", req_cnt, tgt);
  endtask

  task automatic wait_valid(output int c);
    int lim;
    lim = 200;
    @(negedge clk);
    while (!bus.out_valid && lim > 0) begin
      @(negedge clk);
      lim--;
    end
    if (!bus.out_valid) chk("valid_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic rst_on();
    @(posedge clk);
    #2 rst = 1;
    model_reset();
  endtask

  task automatic rst_off();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic settle_und(string nm, int exp);
    repeat (3) @(negedge clk);
    chk(nm, bus.stat_underrun, exp);
  endtask

  initial begin
    int c0, c1;
    bit pb, pv;
    bus.in_data = 0; bus.in_rdy = 1; bus.in_crc_e = 0; bus.in_sa = 0; bus.alarm = 0;
    bus.ctrl_time_src = 0; bus.ext_tick = 0; bus.ctrl_do_framing = 1; bus.ctrl_do_crc4 = 1;
    bus.ctrl_loopback = 0; bus.lb_bit = 0; bus.lb_valid = 0; bus.stat_clr = 0;
    mon_en = 1; ext_en = 0; data_rand = 0; rdy_rand = 0; const_data = 8'h55; clr_next = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_bit", bus.out_bit, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_req", bus.in_req, 0);
    chk("rst_stat", bus.stat_underrun, 0);
    chk("rst_in_frame", bus.in_frame, 15);
    chk("rst_in_ts", bus.in_ts, 31);
    chk("rst_mf_last", bus.in_mf_last, 1);
    chk("rst_mf_first", bus.in_mf_first, 0);
    rst = 0;
    // internal divider, constant 0x55, framing and CRC on
    wait_valid(c0);
    for (int i = 0; i < 4; i++) begin
      wait_valid(c1);
      chk("tick_period", c1 - c0, 15);
      c0 = c1;
    end
    run_reqs(36);
    // external tick, random data and underruns, full multiframe plus for CRC
    rst_on();
    ext_en = 1; bus.ctrl_time_src = 1; data_rand = 1; rdy_rand = 1;
    rst_off();
    run_reqs(720);
    settle_und("underrun_random", model_und);
    // CRC off, all-zero data
    rst_on();
    bus.ctrl_do_crc4 = 0; data_rand = 0; const_data = 8'h00; rdy_rand = 0;
    rst_off();
    run_reqs(330);
    // framing off, forced underruns and clear-vs-increment priority
    rst_on();
    bus.ctrl_do_framing = 0; bus.ctrl_do_crc4 = 1; data_rand = 1;
    rst_off();
    run_reqs(4);
    force_under = 3;
    run_reqs(5);
    settle_und("underrun_three", 3);
    force_under = 1;
    clr_arm = 1;
    run_reqs(3);
    settle_und("underrun_clr", 0);
    run_reqs(20);
    // loopback: line follows lb_* one clock later
    @(negedge clk);
    mon_en = 0;
    bus.ctrl_loopback = 1;
    pb = 0; pv = 1;
    bus.lb_bit = pb; bus.lb_valid = pv;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("lb_bit", bus.out_bit, pb);
      chk("lb_valid", bus.out_valid, pv);
      pb = ~pb;
      pv = 1'($urandom);
      bus.lb_bit = pb;
      bus.lb_valid = pv;
    end
    // mid-frame asynchronous reset
    rst_on();
    bus.ctrl_loopback = 0; bus.ctrl_do_framing = 1; mon_en = 1;
    rst_off();
    run_reqs(50);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_out_bit", bus.out_bit, 1);
    chk("async_in_req", bus.in_req, 0);
    chk("async_in_ts", bus.in_ts, 31);
    chk("async_in_frame", bus.in_frame, 15);
    model_reset();
    rst_off();
    run_reqs(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
